// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction fetch stage with an in-order prefetch queue. A PC generator
// issues requests to a variable-latency instruction memory, following
// next-PC predictions from an external branch predictor. Each issued request
// leaves a {pc, predicted-taken} tag in a small in-flight FIFO. Responses
// return in request order: each one pops a tag and is either enqueued for
// decode or, after a redirect, discarded. Redirects flush the queue and mark
// every outstanding response as "to be dropped".
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   redirect,
//   redirect_pc      : flush and restart fetch at redirect_pc
//   bp_taken,
//   bp_target        : predictor answer for the current fetch_pc
//   fetch_pc         : PC of the next request (predictor lookup index)
//   imem_req/addr    : request valid / address
//   imem_ready       : memory accepts the request this cycle
//   imem_rvalid/rdata: in-order response
//   fq_valid/inst/pc/
//   fq_pred_taken    : head of the fetch queue
//   fq_deq           : decode consumes the head
//   fq_count         : number of occupied queue entries
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter int                PC_STEP  = 2,
  parameter int                FQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        redirect,
  input  logic [ADDR_W-1:0]           redirect_pc,
  input  logic                        bp_taken,
  input  logic [ADDR_W-1:0]           bp_target,
  output logic [ADDR_W-1:0]           fetch_pc,
  output logic                        imem_req,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic                        imem_ready,
  input  logic                        imem_rvalid,
  input  logic [INST_W-1:0]           imem_rdata,
  output logic                        fq_valid,
  output logic [INST_W-1:0]           fq_inst,
  output logic [ADDR_W-1:0]           fq_pc,
  output logic                        fq_pred_taken,
  input  logic                        fq_deq,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0]   PTR_ONE   = PW'(1'b1);
  localparam logic [PW-1:0]   PTR_ZERO  = '0;
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]   CNT_ZERO  = '0;
  // Occupancy is count + inflight, which can reach 2*FQ_DEPTH: one extra bit.
  localparam logic [CW:0]     DEPTH_OCC = (CW+1)'(FQ_DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

  // State registers
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     drop_q,     drop_d;
  logic [PW-1:0]     tag_wr_q,   tag_wr_d;
  logic [PW-1:0]     tag_rd_q,   tag_rd_d;
  logic [PW-1:0]     head_q,     head_d;
  logic [PW-1:0]     tail_q,     tail_d;
  logic [CW-1:0]     count_q,    count_d;

  // Storage arrays (data only, validity is tracked by the pointers/counters)
  logic [ADDR_W-1:0] tag_pc_q   [FQ_DEPTH];
  logic              tag_pred_q [FQ_DEPTH];
  logic [INST_W-1:0] fq_inst_q  [FQ_DEPTH];
  logic [ADDR_W-1:0] fq_pc_q    [FQ_DEPTH];
  logic              fq_pred_q  [FQ_DEPTH];

  // Handshake decodes
  logic [CW:0] occupancy_s;
  logic        issue_s;
  logic        drop_resp_s;
  logic        enq_s;
  logic        deq_s;
  logic        head_valid_s;

  assign occupancy_s  = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req     = ~rst & ~redirect & (occupancy_s < DEPTH_OCC);
  assign issue_s      = imem_req & imem_ready;
  // A response is discarded if it belongs to a pre-redirect request or
  // arrives in the redirect cycle itself.
  assign drop_resp_s  = redirect | (drop_q != CNT_ZERO);
  assign enq_s        = ~rst & imem_rvalid & ~drop_resp_s;
  assign head_valid_s = (count_q != CNT_ZERO);
  assign deq_s        = fq_deq & head_valid_s & ~redirect;

  assign fetch_pc      = fetch_pc_q;
  assign imem_addr     = fetch_pc_q;
  assign fq_valid      = head_valid_s;
  assign fq_count      = count_q;
  // Head is a direct read of the registered array; zero while empty.
  assign fq_inst       = head_valid_s ? fq_inst_q[head_q] : '0;
  assign fq_pc         = head_valid_s ? fq_pc_q[head_q]   : '0;
  assign fq_pred_taken = head_valid_s ? fq_pred_q[head_q] : 1'b0;

  // Next-state logic for PC, counters and pointers
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue_s) begin
      fetch_pc_d = bp_taken ? bp_target : (fetch_pc_q + STEP);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    // Issue never happens with redirect, so this is valid in both cases.
    case ({issue_s, imem_rvalid})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase

    // Recomputing from inflight (not accumulating) keeps nested redirects exact.
    if (redirect) begin
      drop_d = inflight_q - (imem_rvalid ? CNT_ONE : CNT_ZERO);
    end else if (imem_rvalid && (drop_q != CNT_ZERO)) begin
      drop_d = drop_q - CNT_ONE;
    end else begin
      drop_d = drop_q;
    end

    if (issue_s) begin
      tag_wr_d = tag_wr_q + PTR_ONE;
    end else begin
      tag_wr_d = tag_wr_q;
    end

    // Every response pops its tag, dropped or not.
    if (imem_rvalid) begin
      tag_rd_d = tag_rd_q + PTR_ONE;
    end else begin
      tag_rd_d = tag_rd_q;
    end

    if (redirect) begin
      head_d  = PTR_ZERO;
      tail_d  = PTR_ZERO;
      count_d = CNT_ZERO;
    end else begin
      head_d = deq_s ? (head_q + PTR_ONE) : head_q;
      tail_d = enq_s ? (tail_q + PTR_ONE) : tail_q;
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= CNT_ZERO;
      drop_q     <= CNT_ZERO;
      tag_wr_q   <= PTR_ZERO;
      tag_rd_q   <= PTR_ZERO;
      head_q     <= PTR_ZERO;
      tail_q     <= PTR_ZERO;
      count_q    <= CNT_ZERO;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Tag FIFO and fetch-queue data arrays
  always_ff @(posedge clk) begin
    if (issue_s) begin
      tag_pc_q[tag_wr_q]   <= fetch_pc_q;
      tag_pred_q[tag_wr_q] <= bp_taken;
    end
    if (enq_s) begin
      fq_inst_q[tail_q] <= imem_rdata;
      fq_pc_q[tail_q]   <= tag_pc_q[tag_rd_q];
      fq_pred_q[tail_q] <= tag_pred_q[tag_rd_q];
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
//
// Directed bench for fetch_queue_unit. An in-order memory model with a
// settable latency returns inst = addr + 0x1000. Expected values below are
// worked out by hand from the request/response timeline of each scenario.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        bp_taken;
  logic [15:0] bp_target;
  logic [15:0] fetch_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        fq_valid;
  logic [15:0] fq_inst;
  logic [15:0] fq_pc;
  logic        fq_pred_taken;
  logic        fq_deq;
  logic [2:0]  fq_count;

  // Predictor model: one taken branch at bp_pc when enabled.
  logic        bp_en;
  logic [15:0] bp_pc;
  logic [15:0] bp_tgt;
  assign bp_taken  = bp_en && (fetch_pc == bp_pc);
  assign bp_target = bp_tgt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat    = 1;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  fetch_queue_unit dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .bp_taken      (bp_taken),
    .bp_target     (bp_target),
    .fetch_pc      (fetch_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .fq_valid      (fq_valid),
    .fq_inst       (fq_inst),
    .fq_pc         (fq_pc),
    .fq_pred_taken (fq_pred_taken),
    .fq_deq        (fq_deq),
    .fq_count      (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  // Memory model: in-order, latency 'lat', response driven 1 time unit after the edge.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        mq.delete();
      end else begin
        if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
        if (imem_req && imem_ready) mq.push_back('{addr: imem_addr, due: cyc + lat});
      end
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq[0].addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    bp_en = 1'b0; bp_pc = 16'h0000; bp_tgt = 16'h0000;
    imem_ready = 1'b1; fq_deq = 1'b0; lat = 1;

    // ---- Reset state and fill with fq_deq=0, 1-cycle memory ----
    step();
    chk("rst_req", imem_req, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_pc",    fetch_pc, 16'h0000);
    chk("rst_valid", fq_valid, 1'b0);
    chk("rst_count", fq_count, 3'd0);
    chk("rst_inst",  fq_inst, 16'h0000);
    chk("rst_fqpc",  fq_pc, 16'h0000);
    chk("rst_pred",  fq_pred_taken, 1'b0);
    chk("fill_req0", imem_req, 1'b1);
    chk("fill_addr0", imem_addr, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("fill_req", imem_req, 1'b1);
      chk("fill_addr", imem_addr, 16'(2 * k));
    end
    step();
    chk("credit_req", imem_req, 1'b0);
    chk("credit_cnt", fq_count, 3'd3);
    step();
    chk("full_cnt",   fq_count, 3'd4);
    chk("full_req",   imem_req, 1'b0);
    chk("full_valid", fq_valid, 1'b1);
    chk("full_pc",    fq_pc, 16'h0000);
    chk("full_inst",  fq_inst, 16'h1000);

    // ---- Continuous dequeue: one instruction per cycle ----
    fq_deq = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("stream_pc",    fq_pc, 16'(2 * k));
      chk("stream_inst",  fq_inst, 16'(16'h1000 + 2 * k));
      chk("stream_count", fq_count, (k == 1) ? 3'd3 : 3'd2);
    end
    fq_deq = 1'b0;

    // ---- Predicted taken at 0x0004 -> 0x0040 ----
    lat = 1;
    bp_en = 1'b1; bp_pc = 16'h0004; bp_tgt = 16'h0040;
    do_reset();
    fq_deq = 1'b1;
    step();
    step();
    chk("bp_fpc", fetch_pc, 16'h0004);
    step();
    chk("bp_addr", imem_addr, 16'h0040);
    step();
    chk("bp_head_pc",   fq_pc, 16'h0004);
    chk("bp_head_pred", fq_pred_taken, 1'b1);
    step();
    chk("bp_next_pc",   fq_pc, 16'h0040);
    chk("bp_next_pred", fq_pred_taken, 1'b0);
    chk("bp_next_inst", fq_inst, 16'h1040);
    bp_en = 1'b0;
    fq_deq = 1'b0;

    // ---- Redirect to 0x0100 with 3 in flight, 4-cycle memory ----
    lat = 4;
    do_reset();
    step(); step(); step();
    chk("rd_pre_req", imem_req, 1'b1);
    redirect = 1'b1; redirect_pc = 16'h0100;
    #1;
    chk("rd_req_blocked", imem_req, 1'b0);
    step();
    redirect = 1'b0;
    #1;
    chk("rd_addr",  imem_addr, 16'h0100);
    chk("rd_req",   imem_req, 1'b1);
    chk("rd_valid", fq_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_drop_valid", fq_valid, 1'b0);
      chk("rd_drop_count", fq_count, 3'd0);
    end
    step();
    chk("rd_new_valid", fq_valid, 1'b1);
    chk("rd_new_pc",    fq_pc, 16'h0100);
    chk("rd_new_inst",  fq_inst, 16'h1100);

    // ---- Redirect coinciding with rvalid and fq_deq, 2-cycle memory ----
    lat = 2;
    do_reset();
    step(); step(); step(); step();
    chk("rc_pre_count", fq_count, 3'd2);
    chk("rc_pre_req",   imem_req, 1'b0);
    redirect = 1'b1; redirect_pc = 16'h0200; fq_deq = 1'b1;
    step();
    redirect = 1'b0; fq_deq = 1'b0;
    #1;
    chk("rc_count", fq_count, 3'd0);
    chk("rc_valid", fq_valid, 1'b0);
    chk("rc_addr",  imem_addr, 16'h0200);
    step();
    chk("rc_drop_valid1", fq_valid, 1'b0);
    step();
    chk("rc_drop_valid2", fq_valid, 1'b0);
    step();
    chk("rc_new_valid", fq_valid, 1'b1);
    chk("rc_new_pc",    fq_pc, 16'h0200);
    chk("rc_new_count", fq_count, 3'd1);

    // ---- PC wrap from 0xFFFE ----
    lat = 1;
    do_reset();
    fq_deq = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    #1;
    chk("wrap_addr0", imem_addr, 16'hFFFE);
    step();
    chk("wrap_addr1", imem_addr, 16'h0000);
    step();
    chk("wrap_head0_pc",   fq_pc, 16'hFFFE);
    chk("wrap_head0_inst", fq_inst, 16'h0FFE);
    step();
    chk("wrap_head1_pc",   fq_pc, 16'h0000);
    chk("wrap_head1_inst", fq_inst, 16'h1000);
    fq_deq = 1'b0;

    // ---- Reset mid-stream with 2 requests in flight ----
    lat = 2;
    do_reset();
    step(); step(); step();
    chk("mr_pre_valid", fq_valid, 1'b1);
    chk("mr_pre_fpc",   fetch_pc, 16'h0006);
    rst = 1'b1;
    #1;
    chk("mr_req_in_rst", imem_req, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("mr_fpc",   fetch_pc, 16'h0000);
    chk("mr_valid", fq_valid, 1'b0);
    chk("mr_count", fq_count, 3'd0);
    chk("mr_inst",  fq_inst, 16'h0000);
    chk("mr_fqpc",  fq_pc, 16'h0000);
    chk("mr_pred",  fq_pred_taken, 1'b0);
    chk("mr_req",   imem_req, 1'b1);
    step();
    step();
    chk("mr_stale_valid", fq_valid, 1'b0);
    step();
    chk("mr_new_valid", fq_valid, 1'b1);
    chk("mr_new_pc",    fq_pc, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
